// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory bus, aligns stores, extracts loads, registers MEM/WB.
// Latency: 1 edge for non-memory ops and traps; 2 or more edges for bus ops (ends on dmem_ready).
// Backpressure: mem_stall holds upstream while a transfer is outstanding; the bus request is held until dmem_ready.
module mem_stage #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [4:0]        rd,
  input  logic [2:0]        funct3,
  input  logic              reg_write_enable,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              trap_in,
  input  logic [3:0]        trap_cause_in,
  input  logic              flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  input  logic [XLEN-1:0]   dmem_rdata,
  input  logic              dmem_ready,
  output logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   pc_out,
  output logic [4:0]        rd_out,
  output logic              reg_write_enable_out,
  output logic              trap_out,
  output logic [3:0]        trap_cause_out,
  output logic              mem_stall
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);

  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_LD_MISALN = 4'd4;
  localparam logic [3:0] CAUSE_ST_MISALN = 4'd6;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  // Context of the outstanding bus op, captured when leaving IDLE
  logic [4:0]      rd_q, rd_d;
  logic            rwe_q, rwe_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [2:0]      f3_q, f3_d;
  logic [OFS-1:0]  lane_q, lane_d;
  logic            load_q, load_d;
  logic            kill_q, kill_d;

  // Next values of the registered outputs
  logic              req_d, we_d;
  logic [XLEN-1:0]   addr_d, wdata_d;
  logic [NB-1:0]     wstrb_d;
  logic [XLEN-1:0]   wb_data_d, pc_out_d;
  logic [4:0]        rd_out_d;
  logic              rwe_out_d, trap_d;
  logic [3:0]        cause_d;

  // Decode of the incoming op
  logic              is_mem;
  logic [OFS-1:0]    lane;
  logic [OFS-1:0]    size_mask;
  logic              misaligned;
  logic              bad_f3;
  logic [NB-1:0]     strb_base;
  logic [NB-1:0]     store_strb;
  logic [XLEN-1:0]   store_data;
  logic [XLEN-1:0]   load_shifted;
  logic [XLEN-1:0]   load_value;

  // Decode size, alignment, legality and store lane placement of the incoming op
  always_comb begin
    is_mem     = mem_read | mem_write;
    lane       = alu_result[OFS-1:0];
    size_mask  = OFS'((4'd1 << funct3[1:0]) - 4'd1);
    misaligned = (lane & size_mask) != '0;
    if (mem_read) begin
      bad_f3 = (funct3 == 3'b111) ||
               ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
    end else begin
      bad_f3 = funct3[2] || ((XLEN == 32) && (funct3 == 3'b011));
    end
    strb_base = '0;
    for (int i = 0; i < NB; i++) begin
      strb_base[i] = (i < (1 << funct3[1:0]));
    end
    store_strb = strb_base << lane;
    store_data = rs2_data << {lane, 3'b000};
  end

  // Select the addressed bytes of the returned word and extend them to XLEN
  always_comb begin
    load_shifted = dmem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  load_value = XLEN'($signed(load_shifted[7:0]));
      3'b001:  load_value = XLEN'($signed(load_shifted[15:0]));
      3'b010:  load_value = XLEN'($signed(load_shifted[31:0]));
      3'b011:  load_value = load_shifted;
      3'b100:  load_value = XLEN'(load_shifted[7:0]);
      3'b101:  load_value = XLEN'(load_shifted[15:0]);
      3'b110:  load_value = XLEN'(load_shifted[31:0]);
      default: load_value = '0;
    endcase
  end

  // Next-state, stall and next MEM/WB / bus values
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    req_d     = dmem_req;
    we_d      = dmem_we;
    addr_d    = dmem_addr;
    wdata_d   = dmem_wdata;
    wstrb_d   = dmem_wstrb;
    wb_data_d = wb_data;
    pc_out_d  = pc_out;
    rd_out_d  = rd_out;
    rwe_out_d = reg_write_enable_out;
    trap_d    = trap_out;
    cause_d   = trap_cause_out;
    rd_d      = rd_q;
    rwe_d     = rwe_q;
    pc_d      = pc_q;
    alu_d     = alu_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    load_d    = load_q;
    kill_d    = kill_q;

    case (state_q)
      IDLE: begin
        kill_d    = 1'b0;
        // Bubble unless an instruction retires below; a bus op also leaves a
        // bubble in MEM/WB while it waits, so WB never sees a stale duplicate.
        wb_data_d = '0;
        pc_out_d  = '0;
        rd_out_d  = '0;
        rwe_out_d = 1'b0;
        trap_d    = 1'b0;
        cause_d   = '0;
        if (flush) begin
          // killed instruction: bubble, no request
        end else if (trap_in) begin
          wb_data_d = alu_result;
          pc_out_d  = pc_in;
          rd_out_d  = rd;
          trap_d    = 1'b1;
          cause_d   = trap_cause_in;
        end else if (is_mem && bad_f3) begin
          wb_data_d = alu_result;
          pc_out_d  = pc_in;
          rd_out_d  = rd;
          trap_d    = 1'b1;
          cause_d   = CAUSE_ILLEGAL;
        end else if (is_mem && misaligned) begin
          wb_data_d = alu_result;
          pc_out_d  = pc_in;
          rd_out_d  = rd;
          trap_d    = 1'b1;
          cause_d   = mem_read ? CAUSE_LD_MISALN : CAUSE_ST_MISALN;
        end else if (is_mem) begin
          mem_stall = 1'b1;
          state_d   = BUSY;
          req_d     = 1'b1;
          we_d      = mem_write;
          addr_d    = {alu_result[XLEN-1:OFS], {OFS{1'b0}}};
          wdata_d   = mem_write ? store_data : '0;
          wstrb_d   = mem_write ? store_strb : '0;
          rd_d      = rd;
          rwe_d     = reg_write_enable;
          pc_d      = pc_in;
          alu_d     = alu_result;
          f3_d      = funct3;
          lane_d    = lane;
          load_d    = mem_read;
        end else begin
          wb_data_d = alu_result;
          pc_out_d  = pc_in;
          rd_out_d  = rd;
          rwe_out_d = reg_write_enable;
        end
      end
      BUSY: begin
        mem_stall = !dmem_ready;
        if (dmem_ready) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
          kill_d  = 1'b0;
          if (kill_q || flush) begin
            // transfer completed on the bus but the instruction was killed
            wb_data_d = '0;
            pc_out_d  = '0;
            rd_out_d  = '0;
            rwe_out_d = 1'b0;
          end else begin
            wb_data_d = load_q ? load_value : alu_q;
            pc_out_d  = pc_q;
            rd_out_d  = rd_q;
            rwe_out_d = rwe_q;
          end
          trap_d  = 1'b0;
          cause_d = '0;
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Bus outputs, MEM/WB bundle and outstanding-op context
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dmem_req             <= 1'b0;
      dmem_we              <= 1'b0;
      dmem_addr            <= '0;
      dmem_wdata           <= '0;
      dmem_wstrb           <= '0;
      wb_data              <= '0;
      pc_out               <= '0;
      rd_out               <= '0;
      reg_write_enable_out <= 1'b0;
      trap_out             <= 1'b0;
      trap_cause_out       <= '0;
      rd_q                 <= '0;
      rwe_q                <= 1'b0;
      pc_q                 <= '0;
      alu_q                <= '0;
      f3_q                 <= '0;
      lane_q               <= '0;
      load_q               <= 1'b0;
      kill_q               <= 1'b0;
    end else begin
      dmem_req             <= req_d;
      dmem_we              <= we_d;
      dmem_addr            <= addr_d;
      dmem_wdata           <= wdata_d;
      dmem_wstrb           <= wstrb_d;
      wb_data              <= wb_data_d;
      pc_out               <= pc_out_d;
      rd_out               <= rd_out_d;
      reg_write_enable_out <= rwe_out_d;
      trap_out             <= trap_d;
      trap_cause_out       <= cause_d;
      rd_q                 <= rd_d;
      rwe_q                <= rwe_d;
      pc_q                 <= pc_d;
      alu_q                <= alu_d;
      f3_q                 <= f3_d;
      lane_q               <= lane_d;
      load_q               <= load_d;
      kill_q               <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage (XLEN=64): directed cases then random ops against an arithmetic reference model.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Bus ready delays are chosen by the bench; upstream inputs are held while mem_stall is high.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic [63:0] alu_result, rs2_data, pc_in;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        reg_write_enable, mem_read, mem_write, trap_in, flush;
  logic [3:0]  trap_cause_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [63:0] wb_data, pc_out;
  logic [4:0]  rd_out;
  logic        reg_write_enable_out, trap_out, mem_stall;
  logic [3:0]  trap_cause_out;

  int total = 0;
  int bad   = 0;

  mem_stage #(.XLEN(64)) dut (
    .clk(clk), .resetn(resetn),
    .alu_result(alu_result), .rs2_data(rs2_data), .pc_in(pc_in),
    .rd(rd), .funct3(funct3), .reg_write_enable(reg_write_enable),
    .mem_read(mem_read), .mem_write(mem_write),
    .trap_in(trap_in), .trap_cause_in(trap_cause_in), .flush(flush),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .wb_data(wb_data), .pc_out(pc_out), .rd_out(rd_out),
    .reg_write_enable_out(reg_write_enable_out),
    .trap_out(trap_out), .trap_cause_out(trap_cause_out),
    .mem_stall(mem_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_result = '0; rs2_data = '0; pc_in = '0; rd = '0; funct3 = '0;
    reg_write_enable = 0; mem_read = 0; mem_write = 0;
    trap_in = 0; trap_cause_in = '0; flush = 0;
  endtask

  // Reference: value written back by a load, from byte offset and access size
  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] rdata);
    int sz, off;
    logic [63:0] v, m;
    sz  = 1 << f3[1:0];
    off = int'(addr % 8);
    v   = rdata >> (8 * off);
    m   = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v   = v & m;
    if (!f3[2] && sz < 8 && v[8 * sz - 1]) v = v | ~m;
    return v;
  endfunction

  // One instruction through the stage, from issue to retirement.
  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] data, input logic [63:0] rdat, input int dly,
                        input bit tin, input logic [3:0] tcause, input string tag);
    int sz, off, stalls;
    bit legal_f3, aligned, goes_busy, is_mem, rwe;
    logic [3:0]  ecause;
    logic [7:0]  estrb;
    logic [63:0] epc;
    logic [4:0]  erd;
    is_mem   = ld | st;
    sz       = 1 << f3[1:0];
    off      = int'(addr % 8);
    legal_f3 = ld ? (f3 != 3'd7) : (f3 < 3'd4);
    aligned  = (addr % sz) == 0;
    goes_busy = is_mem && !tin && legal_f3 && aligned;
    if (tin)            ecause = tcause;
    else if (!legal_f3) ecause = 4'd2;
    else if (!aligned)  ecause = ld ? 4'd4 : 4'd6;
    else                ecause = 4'd0;
    estrb = 8'(((1 << sz) - 1) << off);
    epc   = {$urandom, $urandom};
    erd   = 5'($urandom);
    rwe   = ld ? 1'b1 : (st ? 1'b0 : 1'($urandom));

    alu_result = addr; rs2_data = data; pc_in = epc; rd = erd; funct3 = f3;
    reg_write_enable = rwe; mem_read = ld; mem_write = st;
    trap_in = tin; trap_cause_in = tcause; flush = 0; dmem_ready = 0;
    #1;
    check({tag, ".stall_issue"}, 64'(mem_stall), 64'(goes_busy));
    stalls = mem_stall ? 1 : 0;
    tick();

    if (!goes_busy) begin
      idle_inputs();
      check({tag, ".no_req"}, 64'(dmem_req), 64'd0);
      check({tag, ".pc"}, pc_out, epc);
      check({tag, ".rd"}, 64'(rd_out), 64'(erd));
      if (is_mem || tin) begin
        check({tag, ".trap"}, 64'(trap_out), 64'd1);
        check({tag, ".cause"}, 64'(trap_cause_out), 64'(ecause));
        check({tag, ".rwe_trap"}, 64'(reg_write_enable_out), 64'd0);
        if (tin) check({tag, ".wb_trap"}, wb_data, addr);
      end else begin
        check({tag, ".trap"}, 64'(trap_out), 64'd0);
        check({tag, ".wb"}, wb_data, addr);
        check({tag, ".rwe"}, 64'(reg_write_enable_out), 64'(rwe));
      end
      return;
    end

    check({tag, ".req"}, 64'(dmem_req), 64'd1);
    check({tag, ".we"}, 64'(dmem_we), 64'(st));
    check({tag, ".addr"}, dmem_addr, addr - (addr % 8));
    check({tag, ".wstrb"}, 64'(dmem_wstrb), st ? 64'(estrb) : 64'd0);
    if (st) check({tag, ".wdata"}, dmem_wdata, data << (8 * off));
    for (int i = 0; i < dly; i++) begin
      dmem_ready = 0;
      #1;
      if (mem_stall) stalls++;
      check({tag, ".req_held"}, 64'(dmem_req), 64'd1);
      check({tag, ".addr_held"}, dmem_addr, addr - (addr % 8));
      check({tag, ".wb_bubble"}, 64'(reg_write_enable_out), 64'd0);
      tick();
    end
    dmem_ready = 1; dmem_rdata = rdat;
    #1;
    check({tag, ".stall_ready"}, 64'(mem_stall), 64'd0);
    tick();
    dmem_ready = 0;
    idle_inputs();
    check({tag, ".stall_count"}, 64'(stalls), 64'(dly + 1));
    check({tag, ".req_done"}, 64'(dmem_req), 64'd0);
    check({tag, ".rwe"}, 64'(reg_write_enable_out), 64'(rwe));
    check({tag, ".rd"}, 64'(rd_out), 64'(erd));
    check({tag, ".pc"}, pc_out, epc);
    check({tag, ".trap"}, 64'(trap_out), 64'd0);
    if (ld) check({tag, ".wb_load"}, wb_data, model_load(f3, addr, rdat));
  endtask

  initial begin
    bit ld, st;
    logic [63:0] a;
    int kind;
    idle_inputs();
    dmem_ready = 0; dmem_rdata = '0;
    resetn = 0;
    #12;
    // reset state
    check("rst.req", 64'(dmem_req), 64'd0);
    check("rst.we", 64'(dmem_we), 64'd0);
    check("rst.addr", dmem_addr, 64'd0);
    check("rst.wstrb", 64'(dmem_wstrb), 64'd0);
    check("rst.wb", wb_data, 64'd0);
    check("rst.pc", pc_out, 64'd0);
    check("rst.rwe", 64'(reg_write_enable_out), 64'd0);
    check("rst.trap", 64'(trap_out), 64'd0);
    @(negedge clk);
    resetn = 1;
    tick();

    // directed cases
    run_op(1, 0, 3'b010, 64'h1004, 64'd0, 64'hDEAD_BEEF_0000_0001, 0, 0, 4'd0, "lw");
    run_op(0, 1, 3'b000, 64'h2003, 64'hAB, 64'd0, 0, 0, 4'd0, "sb");
    run_op(1, 0, 3'b001, 64'h1001, 64'd0, 64'd0, 0, 0, 4'd0, "lh_misaligned");
    run_op(0, 1, 3'b010, 64'h2002, 64'h1234, 64'd0, 0, 0, 4'd0, "sw_misaligned");
    run_op(1, 0, 3'b011, 64'h3000, 64'd0, 64'h8123_4567_89AB_CDEF, 3, 0, 4'd0, "ld_delay3");
    run_op(1, 0, 3'b111, 64'h3000, 64'd0, 64'd0, 0, 0, 4'd0, "ld_illegal");
    run_op(0, 1, 3'b100, 64'h3000, 64'd0, 64'd0, 0, 0, 4'd0, "st_illegal");
    run_op(1, 0, 3'b010, 64'h4000, 64'd0, 64'd0, 0, 1, 4'd9, "trap_in_load");
    run_op(0, 0, 3'b000, 64'h77, 64'd0, 64'd0, 0, 0, 4'd0, "alu");

    // flush in IDLE: a legal load becomes a bubble with no request
    alu_result = 64'h5000; funct3 = 3'b010; mem_read = 1; reg_write_enable = 1; rd = 5'd3; flush = 1;
    #1;
    check("flush_idle.stall", 64'(mem_stall), 64'd0);
    tick();
    idle_inputs();
    check("flush_idle.req", 64'(dmem_req), 64'd0);
    check("flush_idle.rwe", 64'(reg_write_enable_out), 64'd0);
    check("flush_idle.wb", wb_data, 64'd0);

    // flush while BUSY: transfer still completes, result is a bubble
    alu_result = 64'h6008; funct3 = 3'b011; mem_read = 1; reg_write_enable = 1; rd = 5'd7;
    tick();
    idle_inputs();
    flush = 1;
    #1;
    check("flush_busy.stall", 64'(mem_stall), 64'd1);
    tick();
    flush = 0;
    check("flush_busy.req_held", 64'(dmem_req), 64'd1);
    check("flush_busy.addr_held", dmem_addr, 64'h6008);
    tick();
    check("flush_busy.req_still", 64'(dmem_req), 64'd1);
    dmem_ready = 1; dmem_rdata = 64'h1111_2222_3333_4444;
    tick();
    dmem_ready = 0;
    check("flush_busy.req_done", 64'(dmem_req), 64'd0);
    check("flush_busy.rwe", 64'(reg_write_enable_out), 64'd0);
    check("flush_busy.wb", wb_data, 64'd0);

    // flush coinciding with ready
    alu_result = 64'h6010; funct3 = 3'b010; mem_read = 1; reg_write_enable = 1; rd = 5'd9;
    tick();
    idle_inputs();
    flush = 1; dmem_ready = 1; dmem_rdata = 64'h55;
    tick();
    flush = 0; dmem_ready = 0;
    check("flush_ready.rwe", 64'(reg_write_enable_out), 64'd0);
    check("flush_ready.req", 64'(dmem_req), 64'd0);
    run_op(0, 0, 3'b000, 64'h99, 64'd0, 64'd0, 0, 0, 4'd0, "after_flush_ready");

    // reset while BUSY drops the request at once
    alu_result = 64'h7000; funct3 = 3'b011; mem_read = 1; reg_write_enable = 1; rd = 5'd4;
    tick();
    idle_inputs();
    check("rst_busy.req_before", 64'(dmem_req), 64'd1);
    resetn = 0;
    #1;
    check("rst_busy.req", 64'(dmem_req), 64'd0);
    @(negedge clk);
    resetn = 1;
    tick();
    alu_result = 64'd5; reg_write_enable = 1; rd = 5'd1;
    tick();
    idle_inputs();
    check("rst_busy.add_wb", wb_data, 64'd5);
    check("rst_busy.add_rwe", 64'(reg_write_enable_out), 64'd1);

    // random ops
    for (int n = 0; n < 120; n++) begin
      kind = int'($urandom_range(0, 2));
      ld = (kind == 0);
      st = (kind == 1);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
      run_op(ld, st, 3'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 4'($urandom), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
